// File: rtl/gate_sensor_decoder.sv
// -----------------------------------------------------------------------------
// gate_sensor_decoder
//
// Front end for a single-lane parking gate. Two raw IR beams (A = street side,
// B = lot side) are synchronised, debounced and walked through a direction
// FSM. A full A -> AB -> B -> clear crossing yields one entry_pulse, and the
// mirror sequence yields one exit_pulse. Impossible beam combinations and
// beams that stay blocked too long drive the FSM into ERR. ERR raises a
// one-cycle fault and then waits for both beams to clear.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sensor_a     raw outer beam, 1 = blocked (asynchronous)
//   sensor_b     raw inner beam, 1 = blocked (asynchronous)
//   entry_pulse  one-cycle pulse per completed entry
//   exit_pulse   one-cycle pulse per completed exit
//   fault        one-cycle pulse on entering ERR
//   busy         high whenever the FSM is not IDLE
//   state_dbg    current FSM state encoding
// -----------------------------------------------------------------------------
module gate_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       fault,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ENT1 = 3'd1,
        ENT2 = 3'd2,
        ENT3 = 3'd3,
        EXT1 = 3'd4,
        EXT2 = 3'd5,
        EXT3 = 3'd6,
        ERR  = 3'd7
    } state_t;

    // Channel index 1 carries beam A and index 0 carries beam B, so that a
    // two-bit vector reads as {a, b}.
    logic [1:0]           raw_s;
    logic [1:0]           sync1_r;
    logic [1:0]           sync2_r;
    logic [1:0]           db_r;
    logic [1:0][DB_W-1:0] cnt_r;

    state_t               state_r;
    state_t               trans_s;
    state_t               next_s;
    logic [TO_W-1:0]      tcnt_r;
    logic                 entry_s;
    logic                 exit_s;
    logic                 entry_r;
    logic                 exit_r;
    logic                 fault_r;
    logic                 busy_r;

    assign raw_s = {sensor_a, sensor_b};

    // Two-flop synchroniser followed by a per-channel stability counter. The
    // debounced value flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            db_r    <= 2'b00;
            cnt_r   <= {2{DB_ZERO}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2_r[ch] != db_r[ch]) begin
                    if (cnt_r[ch] == DB_LAST) begin
                        db_r[ch]  <= sync2_r[ch];
                        cnt_r[ch] <= DB_ZERO;
                    end else begin
                        cnt_r[ch] <= cnt_r[ch] + DB_ONE;
                    end
                end else begin
                    cnt_r[ch] <= DB_ZERO;
                end
            end
        end
    end

    // Legal direction-FSM moves from the debounced beam vector. Any beam
    // combination not listed for a state keeps the FSM where it is.
    always_comb begin
        trans_s = state_r;
        entry_s = 1'b0;
        exit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                case (db_r)
                    2'b10:   trans_s = ENT1;
                    2'b01:   trans_s = EXT1;
                    2'b11:   trans_s = ERR;
                    default: trans_s = IDLE;
                endcase
            end
            ENT1: begin
                case (db_r)
                    2'b11:   trans_s = ENT2;
                    2'b00:   trans_s = IDLE;
                    2'b01:   trans_s = ERR;
                    default: trans_s = ENT1;
                endcase
            end
            ENT2: begin
                case (db_r)
                    2'b01:   trans_s = ENT3;
                    2'b10:   trans_s = ENT1;
                    2'b00:   trans_s = ERR;
                    default: trans_s = ENT2;
                endcase
            end
            ENT3: begin
                case (db_r)
                    2'b00: begin
                        trans_s = IDLE;
                        entry_s = 1'b1;
                    end
                    2'b11:   trans_s = ENT2;
                    2'b10:   trans_s = ERR;
                    default: trans_s = ENT3;
                endcase
            end
            EXT1: begin
                case (db_r)
                    2'b11:   trans_s = EXT2;
                    2'b00:   trans_s = IDLE;
                    2'b10:   trans_s = ERR;
                    default: trans_s = EXT1;
                endcase
            end
            EXT2: begin
                case (db_r)
                    2'b10:   trans_s = EXT3;
                    2'b01:   trans_s = EXT1;
                    2'b00:   trans_s = ERR;
                    default: trans_s = EXT2;
                endcase
            end
            EXT3: begin
                case (db_r)
                    2'b00: begin
                        trans_s = IDLE;
                        exit_s  = 1'b1;
                    end
                    2'b11:   trans_s = EXT2;
                    2'b01:   trans_s = ERR;
                    default: trans_s = EXT3;
                endcase
            end
            ERR: begin
                if (db_r == 2'b00) begin
                    trans_s = IDLE;
                end else begin
                    trans_s = ERR;
                end
            end
            default: trans_s = IDLE;
        endcase
    end

    // Stuck-beam timeout. It only fires when no legal move happens in the same
    // cycle, so a real transition always wins over the timeout.
    always_comb begin
        next_s = trans_s;
        if ((trans_s == state_r) && (state_r != IDLE) && (state_r != ERR)
            && (tcnt_r == TO_LAST)) begin
            next_s = ERR;
        end else begin
            next_s = trans_s;
        end
    end

    // State register, dwell counter and registered event outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            tcnt_r  <= TO_ZERO;
            entry_r <= 1'b0;
            exit_r  <= 1'b0;
            fault_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            if ((next_s != state_r) || (state_r == IDLE) || (state_r == ERR)) begin
                tcnt_r <= TO_ZERO;
            end else begin
                tcnt_r <= tcnt_r + TO_ONE;
            end
            // The completion pulses come from moves to IDLE, which the
            // timeout never overrides, so they cannot coincide with fault.
            entry_r <= entry_s;
            exit_r  <= exit_s;
            fault_r <= (next_s == ERR) && (state_r != ERR);
            busy_r  <= (next_s != IDLE);
        end
    end

    assign entry_pulse = entry_r;
    assign exit_pulse  = exit_r;
    assign fault       = fault_r;
    assign busy        = busy_r;
    assign state_dbg   = state_r;

endmodule
